fpu_addsub_arbiter: RTL and testbench

- Round-robin scheduler that shares one floating-point add/subtract unit (operand registers plus its sequencing FSM) among N_REQ requesters in the estimation system.
- Grants one requester, latches its operands, pulses the unit's begin, waits for ready, returns the result, then returns the unit to its start state with its FSM reset before the next grant.
- Includes a per-operation watchdog so a hung unit cannot stall the linearizer/normalizer pipeline.

---
 rtl/fpu_addsub_arbiter.sv | 143 ++++++++++++++
 tb/tb_fpu_addsub_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin arbiter sharing one floating-point add/sub unit among N_REQ requesters,
// with operand capture, begin/ready sequencing, FSM release and a per-operation watchdog.
module fpu_addsub_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [N_REQ*W-1:0] op_a_i,
    input  logic [N_REQ*W-1:0] op_b_i,
    input  logic [N_REQ-1:0]   sub_i,
    output logic [N_REQ-1:0]   gnt_o,
    output logic [N_REQ-1:0]   done_o,
    output logic [N_REQ-1:0]   err_o,
    output logic [W-1:0]       result_o,
    output logic               busy_o,
    output logic               fpu_beg_o,
    output logic               fpu_rst_fsm_o,
    output logic [W-1:0]       fpu_op_a_o,
    output logic [W-1:0]       fpu_op_b_o,
    output logic               fpu_sub_o,
    input  logic               fpu_ready_i,
    input  logic [W-1:0]       fpu_result_i
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               abort_q;
    logic [W-1:0]       op_a_q, op_b_q, result_q;
    logic               sub_q;
    logic               win_vld;
    logic [PTR_W-1:0]   win_idx;
    logic               timeout_hit;

    // Search from ptr+1 around the ring; scanning farthest-first lets the nearest hit win.
    function automatic logic [PTR_W:0] pick_winner(input logic [N_REQ-1:0] req,
                                                   input logic [PTR_W-1:0] ptr);
        logic [PTR_W:0]   r;
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        r = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(off);
            if (sum >= (PTR_W+1)'(N_REQ))
                sum = sum - (PTR_W+1)'(N_REQ);
            idx = sum[PTR_W-1:0];
            if (req[idx])
                r = {1'b1, idx};
        end
        return r;
    endfunction

    always_comb begin
        {win_vld, win_idx} = pick_winner(req_i, ptr_q);
    end

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (win_vld) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT:    if (fpu_ready_i || timeout_hit) state_d = S_DONE;
            S_DONE:    state_d = S_RELEASE;
            S_RELEASE: if (abort_q || !fpu_ready_i) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= PTR_W'(N_REQ - 1);
            gnt_q    <= '0;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            sub_q    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_vld) begin
                        gnt_q  <= N_REQ'(1) << win_idx;
                        ptr_q  <= win_idx;
                        op_a_q <= op_a_i[int'(win_idx)*W +: W];
                        op_b_q <= op_b_i[int'(win_idx)*W +: W];
                        sub_q  <= sub_i[win_idx];
                    end
                end
                S_ISSUE: cnt_q <= '0;
                S_WAIT: begin
                    if (fpu_ready_i) begin
                        result_q <= fpu_result_i;
                    end else if (timeout_hit) begin
                        result_q <= '0;
                        abort_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: gnt_q <= '0;
                S_RELEASE: if (abort_q || !fpu_ready_i) abort_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign gnt_o         = gnt_q;
    assign done_o        = (state_q == S_DONE) ? gnt_q : '0;
    assign err_o         = (state_q == S_DONE && abort_q) ? gnt_q : '0;
    assign result_o      = result_q;
    assign busy_o        = (state_q != S_IDLE);
    assign fpu_beg_o     = (state_q == S_ISSUE);
    assign fpu_rst_fsm_o = (state_q == S_RELEASE) && (abort_q || fpu_ready_i);
    assign fpu_op_a_o    = op_a_q;
    assign fpu_op_b_o    = op_b_q;
    assign fpu_sub_o     = sub_q;

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Directed bench for fpu_addsub_arbiter with a behavioural add/sub unit model
// whose ready latency and result are set per step.
module tb_fpu_addsub_arbiter;

    logic          clk;
    logic          rst;
    logic [3:0]    req;
    logic [127:0]  op_a, op_b;
    logic [3:0]    sub;
    logic [3:0]    gnt_o, done_o, err_o;
    logic [31:0]   result_o;
    logic          busy_o, fpu_beg_o, fpu_rst_fsm_o, fpu_sub_o;
    logic [31:0]   fpu_op_a_o, fpu_op_b_o;
    logic          fpu_ready_i;
    logic [31:0]   fpu_result_i;

    logic          ready_q, ready_force, pend;
    int            dcnt;
    int            model_lat;
    logic [31:0]   model_res;

    int n_tests = 0;
    int n_fail  = 0;

    fpu_addsub_arbiter #(.N_REQ(4), .W(32), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req_i(req), .op_a_i(op_a), .op_b_i(op_b), .sub_i(sub),
        .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .result_o(result_o),
        .busy_o(busy_o), .fpu_beg_o(fpu_beg_o), .fpu_rst_fsm_o(fpu_rst_fsm_o),
        .fpu_op_a_o(fpu_op_a_o), .fpu_op_b_o(fpu_op_b_o), .fpu_sub_o(fpu_sub_o),
        .fpu_ready_i(fpu_ready_i), .fpu_result_i(fpu_result_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Add/sub unit model: ready rises model_lat edges after begin is sampled (never if 0)
    assign fpu_ready_i  = ready_q | ready_force;
    assign fpu_result_i = model_res;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
            pend    <= 1'b0;
            dcnt    <= 0;
        end else if (fpu_rst_fsm_o) begin
            ready_q <= 1'b0;
            pend    <= 1'b0;
        end else if (fpu_beg_o) begin
            pend <= 1'b1;
            dcnt <= 0;
        end else if (pend) begin
            if (model_lat != 0 && dcnt == model_lat - 1) begin
                ready_q <= 1'b1;
                pend    <= 1'b0;
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_op(input string tag, input logic [3:0] exp_gnt, input int lat,
                         input logic [31:0] res, input logic [31:0] exp_res,
                         input logic exp_err, input int exp_wait);
        int n;
        model_lat = lat;
        model_res = res;
        n = 0;
        while (fpu_beg_o !== 1'b1 && n < 40) begin tick(); n++; end
        chk({tag, "_beg"}, 64'(fpu_beg_o), 64'd1);
        chk({tag, "_gnt"}, 64'(gnt_o), 64'(exp_gnt));
        n = 0;
        while (done_o === 4'b0000 && n < 200) begin tick(); n++; end
        chk({tag, "_lat"}, 64'(n), 64'(exp_wait));
        chk({tag, "_done"}, 64'(done_o), 64'(exp_gnt));
        chk({tag, "_err"}, 64'(err_o), exp_err ? 64'(exp_gnt) : 64'd0);
        chk({tag, "_res"}, 64'(result_o), 64'(exp_res));
    endtask

    initial begin
        int n, gap;
        rst = 1'b1; req = 4'b0; sub = 4'b0; ready_force = 1'b0;
        model_lat = 0; model_res = 32'h0;
        op_a = {32'h41000000, 32'h40E00000, 32'h40C00000, 32'h3F800000};
        op_b = {32'h3F800000, 32'h40A00000, 32'h40800000, 32'h40000000};
        tick(); tick();

        // Reset state
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_beg", 64'(fpu_beg_o), 64'd0);
        chk("rst_rstfsm", 64'(fpu_rst_fsm_o), 64'd0);
        chk("rst_result", 64'(result_o), 64'd0);
        chk("rst_opa", 64'(fpu_op_a_o), 64'd0);
        rst = 1'b0;
        tick();

        // Ready high in IDLE with no request is ignored
        ready_force = 1'b1;
        tick(); tick();
        chk("idle_ready_busy", 64'(busy_o), 64'd0);
        chk("idle_ready_done", 64'(done_o), 64'd0);
        ready_force = 1'b0;
        tick();

        // Single op: 1.0 + 2.0 = 3.0, ready 5 cycles after begin
        model_lat = 5; model_res = 32'h40400000;
        req = 4'b0001;
        tick();
        chk("single_gnt", 64'(gnt_o), 64'h1);
        chk("single_beg", 64'(fpu_beg_o), 64'd1);
        chk("single_opa", 64'(fpu_op_a_o), 64'h3F800000);
        chk("single_opb", 64'(fpu_op_b_o), 64'h40000000);
        chk("single_sub", 64'(fpu_sub_o), 64'd0);
        op_a[31:0] = 32'hDEADBEEF;
        tick();
        chk("single_beg_pulse", 64'(fpu_beg_o), 64'd0);
        n = 1;
        while (done_o === 4'b0000 && n < 100) begin tick(); n++; end
        chk("single_lat", 64'(n), 64'd7);
        chk("single_done", 64'(done_o), 64'h1);
        chk("single_err", 64'(err_o), 64'd0);
        chk("single_res", 64'(result_o), 64'h40400000);
        chk("isolate_opa", 64'(fpu_op_a_o), 64'h3F800000);
        req = 4'b0;
        tick();
        chk("single_done_pulse", 64'(done_o), 64'd0);
        chk("single_rstfsm", 64'(fpu_rst_fsm_o), 64'd1);
        chk("single_gnt_clr", 64'(gnt_o), 64'd0);
        tick();
        chk("single_rstfsm_off", 64'(fpu_rst_fsm_o), 64'd0);
        chk("single_busy_rel", 64'(busy_o), 64'd1);
        tick();
        chk("single_busy_idle", 64'(busy_o), 64'd0);
        op_a[31:0] = 32'h3F800000;

        // Contention: requesters 1 and 2 held
        req = 4'b0110;
        do_op("cont0", 4'b0010, 3, 32'h41300000, 32'h41300000, 1'b0, 5);
        do_op("cont1", 4'b0100, 4, 32'h41200000, 32'h41200000, 1'b0, 6);
        do_op("cont2", 4'b0010, 3, 32'h41300000, 32'h41300000, 1'b0, 5);
        req = 4'b0;

        // Timeout: ready never rises
        req = 4'b0100;
        do_op("tmo", 4'b0100, 0, 32'h12345678, 32'h0, 1'b1, 65);
        req = 4'b0;
        tick();
        chk("tmo_rstfsm", 64'(fpu_rst_fsm_o), 64'd1);
        chk("tmo_err_pulse", 64'(err_o), 64'd0);
        tick();
        chk("tmo_rstfsm_off", 64'(fpu_rst_fsm_o), 64'd0);
        chk("tmo_busy_idle", 64'(busy_o), 64'd0);
        req = 4'b0001;
        do_op("after_tmo", 4'b0001, 3, 32'h40400000, 32'h40400000, 1'b0, 5);
        req = 4'b0;

        // Reset in WAIT
        req = 4'b0010;
        model_lat = 0;
        n = 0;
        while (fpu_beg_o !== 1'b1 && n < 40) begin tick(); n++; end
        chk("mid_gnt", 64'(gnt_o), 64'h2);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 64'(gnt_o), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_result", 64'(result_o), 64'd0);
        chk("mid_rst_opa", 64'(fpu_op_a_o), 64'd0);
        tick();
        rst = 1'b0;
        req = 4'b1010;
        do_op("ptr_rst", 4'b0010, 3, 32'h41400000, 32'h41400000, 1'b0, 5);
        req = 4'b1000;
        do_op("req3", 4'b1000, 2, 32'h41100000, 32'h41100000, 1'b0, 4);
        req = 4'b0;
        tick(); tick(); tick();

        // Fairness: all four held for eight transactions
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("fair%0d", i), 4'(1 << (i % 4)), 2, 32'h40000000 + i,
                  32'h40000000 + i, 1'b0, 4);
            if (i < 7) begin
                n = 0;
                while (busy_o === 1'b1 && n < 10) begin tick(); n++; end
                gap = 0;
                while (busy_o === 1'b0 && gap < 10) begin tick(); gap++; end
                chk($sformatf("fair_gap%0d", i), 64'(gap), 64'd1);
            end
        end
        req = 4'b0;
        tick(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
